// File: rtl/floppy_pkg.sv
// Shared definitions for the Disk II track loader: geometry constants and FSM state encoding.
package floppy_pkg;

  localparam int TRACK_BYTES  = 6656;
  localparam int SECTOR_BYTES = 512;

  localparam int TRACK_SECTORS_DEF = TRACK_BYTES / SECTOR_BYTES;
  localparam int NUM_TRACKS_DEF    = 35;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/settle_timer.sv
// Retriggerable down-counter: reloads while armed or whenever its watched input changes,
// and reports expiry once the input has been stable for CYCLES consecutive unarmed cycles.
module settle_timer #(
  parameter int CYCLES = 14318,
  parameter int W      = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         arm,
  input  logic [W-1:0] din,
  output logic         expired
);

  localparam int          CW     = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  din_q;
  logic          changed;

  assign changed = (din != din_q);
  assign expired = !arm && !changed && (cnt == '0);

  // Track the watched input and count down, restarting on arm or on any input change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      din_q <= '0;
    end else begin
      din_q <= din;
      if (arm || changed) begin
        cnt <= RELOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/floppy_track_loader.sv
// Streams one nibble track from the SD block interface into the Disk II track RAM,
// reloading once the head has settled on a new track or a new image is mounted.
module floppy_track_loader
  import floppy_pkg::*;
#(
  parameter int TRACK_SECTORS = TRACK_SECTORS_DEF,
  parameter int NUM_TRACKS    = NUM_TRACKS_DEF,
  parameter int SETTLE_CYCLES = 14318
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic        img_mounted,
  input  logic        img_present,
  input  logic [5:0]  TRACK,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [12:0] DISK_RAM_ADDR,
  output logic [7:0]  DISK_RAM_DI,
  output logic        DISK_RAM_WE,
  output logic        loading,
  output logic        track_valid,
  output logic [5:0]  loaded_track
);

  localparam logic [31:0] SECT32   = 32'(TRACK_SECTORS);
  localparam logic [3:0]  LAST_IDX = 4'(TRACK_SECTORS - 1);
  localparam logic [6:0]  NT7      = 7'(NUM_TRACKS);

  loader_state_t state;
  logic [5:0]    tgt;
  logic [3:0]    idx;
  logic          pending;
  logic          settled;
  logic          evt;
  logic          byte_wr;

  function automatic logic [31:0] lba_of(input logic [5:0] trk, input logic [3:0] sec);
    return 32'(trk) * SECT32 + 32'(sec);
  endfunction

  function automatic logic in_range(input logic [5:0] trk);
    return ({1'b0, trk} < NT7);
  endfunction

  // Anything that makes the track being loaded stale; one flag absorbs coincident events.
  assign evt     = img_mounted || (TRACK != tgt) || !img_present;
  assign byte_wr = (state == ST_XFER) && sd_buff_wr;

  settle_timer #(
    .CYCLES (SETTLE_CYCLES),
    .W      (6)
  ) u_settle (
    .clk     (CLK_14M),
    .rst_n   (RESET_N),
    .arm     (state != ST_SETTLE),
    .din     (TRACK),
    .expired (settled)
  );

  // Load sequencer: settle, request each sector, wait out its transfer, publish the result.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      tgt          <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      sd_rd        <= 1'b0;
      sd_lba       <= '0;
      loading      <= 1'b0;
      track_valid  <= 1'b0;
      loaded_track <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!img_present) track_valid <= 1'b0;
          if (pending || img_mounted || (TRACK != loaded_track) ||
              (!track_valid && img_present && in_range(TRACK))) begin
            pending <= 1'b0;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!img_present || !in_range(TRACK)) begin
            track_valid <= 1'b0;
            loading     <= 1'b0;
            state       <= ST_IDLE;
          end else if (settled) begin
            tgt         <= TRACK;
            idx         <= '0;
            track_valid <= 1'b0;
            sd_lba      <= lba_of(TRACK, 4'd0);
            sd_rd       <= 1'b1;
            loading     <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (evt) pending <= 1'b1;
          if (sd_ack) begin
            sd_rd <= 1'b0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // The sector in flight always runs to the end of its sd_ack window.
          if (evt) pending <= 1'b1;
          if (!sd_ack) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (pending || evt) begin
            pending <= 1'b0;
            state   <= ST_SETTLE;
          end else if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx    <= idx + 4'd1;
            sd_lba <= lba_of(tgt, idx + 4'd1);
            sd_rd  <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_DONE: begin
          if (evt) pending <= 1'b1;
          loaded_track <= tgt;
          track_valid  <= 1'b1;
          loading      <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register each SD buffer byte into the track RAM one cycle after its strobe.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      DISK_RAM_WE   <= 1'b0;
      DISK_RAM_ADDR <= '0;
      DISK_RAM_DI   <= '0;
    end else begin
      DISK_RAM_WE <= byte_wr;
      if (byte_wr) begin
        DISK_RAM_ADDR <= {idx, sd_buff_addr};
        DISK_RAM_DI   <= sd_buff_dout;
      end
    end
  end

endmodule

// File: tb/tb_floppy_track_loader.sv
// Self-checking bench for floppy_track_loader: an SD host model serves sectors, every
// byte strobed is queued as an expected RAM write and matched against DISK_RAM_* by a monitor.
module tb_floppy_track_loader;

  // Settle time shortened so each scenario spends its cycles on byte traffic.
  localparam int SETTLE   = 300;
  localparam int SECTORS  = 13;
  localparam int WAIT_MAX = 2000;

  logic        CLK_14M;
  logic        RESET_N;
  logic        img_mounted;
  logic        img_present;
  logic [5:0]  TRACK;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [12:0] DISK_RAM_ADDR;
  logic [7:0]  DISK_RAM_DI;
  logic        DISK_RAM_WE;
  logic        loading;
  logic        track_valid;
  logic [5:0]  loaded_track;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  floppy_track_loader #(
    .TRACK_SECTORS (SECTORS),
    .NUM_TRACKS    (35),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .CLK_14M       (CLK_14M),
    .RESET_N       (RESET_N),
    .img_mounted   (img_mounted),
    .img_present   (img_present),
    .TRACK         (TRACK),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_wr    (sd_buff_wr),
    .DISK_RAM_ADDR (DISK_RAM_ADDR),
    .DISK_RAM_DI   (DISK_RAM_DI),
    .DISK_RAM_WE   (DISK_RAM_WE),
    .loading       (loading),
    .track_valid   (track_valid),
    .loaded_track  (loaded_track)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  always @(posedge CLK_14M) cyc <= cyc + 1;

  // Scoreboard: every RAM write must match the next queued byte, on the expected cycle.
  always @(negedge CLK_14M) begin
    if (DISK_RAM_WE === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %02h at cycle %0d, required no write",
                 DISK_RAM_ADDR, DISK_RAM_DI, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (DISK_RAM_ADDR !== mon_e.addr || DISK_RAM_DI !== mon_e.data || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL ram_write: got addr %0d data %02h cycle %0d, required addr %0d data %02h cycle %0d",
                   DISK_RAM_ADDR, DISK_RAM_DI, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK_14M);
    #1;
  endtask

  // SD host: wait for a request, check it, transfer 512 bytes, optionally move the head mid-sector.
  task automatic serve_sector(input int exp_lba, input int sec, input int chg_at,
                              input logic [5:0] chg_trk, output int waited, output bit ok);
    wr_t e;
    int  t;
    t = 0;
    while (sd_rd !== 1'b1 && t < WAIT_MAX) begin
      tick();
      t++;
    end
    waited = t;
    ok     = (sd_rd === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL request_timeout: sd_rd %b after %0d cycles, required request for lba %0d",
               sd_rd, t, exp_lba);
    end else begin
      checks++;
      if (sd_lba !== 32'(exp_lba)) begin
        errors++;
        $display("FAIL lba: got %0d, required %0d", sd_lba, exp_lba);
      end
      checks++;
      if (loading !== 1'b1 || track_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_flags: loading %b track_valid %b, required 1 0", loading, track_valid);
      end
      repeat (3) tick();
      checks++;
      if (sd_rd !== 1'b1 || sd_lba !== 32'(exp_lba)) begin
        errors++;
        $display("FAIL req_hold: sd_rd %b lba %0d, required 1 %0d", sd_rd, sd_lba, exp_lba);
      end
      sd_ack = 1'b1;
      tick();
      checks++;
      if (sd_rd !== 1'b0) begin
        errors++;
        $display("FAIL rd_drop: sd_rd %b after ack, required 0", sd_rd);
      end
      for (int i = 0; i < 512; i++) begin
        if (i == chg_at) TRACK = chg_trk;
        sd_buff_wr   = 1'b1;
        sd_buff_addr = 9'(i);
        sd_buff_dout = 8'($urandom);
        e.addr = 13'(sec * 512 + i);
        e.data = sd_buff_dout;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        tick();
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
    end
  endtask

  // Serve a whole track and check it is published as loaded.
  task automatic serve_track(input int trk, output int w0);
    int w;
    int t;
    bit ok;
    w0 = 0;
    for (int k = 0; k < SECTORS; k++) begin
      serve_sector(trk * SECTORS + k, k, -1, 6'd0, w, ok);
      if (k == 0) w0 = w;
      if (!ok) break;
    end
    t = 0;
    while (track_valid !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (track_valid !== 1'b1 || loaded_track !== 6'(trk) || loading !== 1'b0) begin
      errors++;
      $display("FAIL track_done: valid %b loaded %0d loading %b, required 1 %0d 0",
               track_valid, loaded_track, loading, trk);
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_pending: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    img_mounted = 1'b0; img_present = 1'b0; TRACK = 6'd0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sd_lba, sd_rd, DISK_RAM_ADDR, DISK_RAM_DI, DISK_RAM_WE, loading, track_valid, loaded_track} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: lba %0d rd %b addr %0d di %0d we %b loading %b valid %b track %0d, required all 0",
               sd_lba, sd_rd, DISK_RAM_ADDR, DISK_RAM_DI, DISK_RAM_WE, loading, track_valid, loaded_track);
    end
    RESET_N = 1'b1;
    repeat (50) tick();
    checks++;
    if (sd_rd !== 1'b0 || loading !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_image: sd_rd %b loading %b, required 0 0", sd_rd, loading);
    end
  endtask

  task automatic test_stray_strobe();
    int we_seen;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = 8'hA5;
      tick();
      if (DISK_RAM_WE === 1'b1) we_seen++;
    end
    sd_buff_wr = 1'b0;
    tick();
    if (DISK_RAM_WE === 1'b1) we_seen++;
    checks++;
    if (we_seen != 0) begin
      errors++;
      $display("FAIL stray_strobe: %0d write cycles in idle, required 0", we_seen);
    end
  endtask

  task automatic test_boot();
    int w;
    img_present = 1'b1;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    serve_track(0, w);
  endtask

  task automatic test_seek();
    int w;
    TRACK = 6'd17;
    serve_track(17, w);
    checks++;
    if (w < SETTLE || w > SETTLE + 4) begin
      errors++;
      $display("FAIL seek_settle: first request after %0d cycles, required %0d..%0d", w, SETTLE, SETTLE + 4);
    end
  endtask

  task automatic test_stepping();
    int w;
    int rd_seen;
    rd_seen = 0;
    for (int s = 1; s <= 2; s++) begin
      TRACK = 6'(s);
      for (int i = 0; i < SETTLE / 3; i++) begin
        tick();
        if (sd_rd === 1'b1) rd_seen++;
      end
    end
    checks++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL step_early_request: %0d request cycles while stepping, required 0", rd_seen);
    end
    TRACK = 6'd3;
    serve_track(3, w);
    rd_seen = 0;
    for (int i = 0; i < 2 * SETTLE; i++) begin
      tick();
      if (sd_rd === 1'b1) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL step_extra_load: %0d request cycles after load, required 0", rd_seen);
    end
  endtask

  task automatic test_midload_change();
    int w;
    bit ok;
    TRACK = 6'd10;
    for (int k = 0; k < 5; k++) serve_sector(130 + k, k, -1, 6'd0, w, ok);
    serve_sector(135, 5, 100, 6'd11, w, ok);
    serve_track(11, w);
  endtask

  task automatic test_mount_and_seek();
    int w;
    int rd_seen;
    TRACK = 6'd34;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    serve_track(34, w);
    checks++;
    if (sd_lba !== 32'd454) begin
      errors++;
      $display("FAIL last_lba: got %0d, required 454", sd_lba);
    end
    rd_seen = 0;
    for (int i = 0; i < 2 * SETTLE; i++) begin
      tick();
      if (sd_rd === 1'b1) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL double_reload: %0d request cycles after load, required 0", rd_seen);
    end
  endtask

  task automatic test_eject();
    int rd_seen;
    img_present = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 2 * SETTLE; i++) begin
      tick();
      if (sd_rd === 1'b1) rd_seen++;
    end
    checks++;
    if (track_valid !== 1'b0 || loading !== 1'b0 || rd_seen != 0) begin
      errors++;
      $display("FAIL eject: valid %b loading %b requests %0d, required 0 0 0", track_valid, loading, rd_seen);
    end
  endtask

  task automatic test_out_of_range();
    int rd_seen;
    img_present = 1'b1;
    TRACK = 6'd40;
    rd_seen = 0;
    for (int i = 0; i < 2 * SETTLE; i++) begin
      tick();
      if (sd_rd === 1'b1) rd_seen++;
    end
    checks++;
    if (track_valid !== 1'b0 || loading !== 1'b0 || rd_seen != 0) begin
      errors++;
      $display("FAIL out_of_range: valid %b loading %b requests %0d, required 0 0 0", track_valid, loading, rd_seen);
    end
  endtask

  task automatic test_reset_mid_xfer();
    wr_t e;
    int  t;
    int  we_seen;
    TRACK = 6'd5;
    t = 0;
    while (sd_rd !== 1'b1 && t < WAIT_MAX) begin
      tick();
      t++;
    end
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'd65) begin
      errors++;
      $display("FAIL pre_reset_req: sd_rd %b lba %0d, required 1 65", sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = 8'($urandom);
      e.addr = 13'(i); e.data = sd_buff_dout; e.cyc = cyc + 1;
      exp_q.push_back(e);
      tick();
    end
    sd_buff_wr = 1'b0;
    tick();
    RESET_N = 1'b0;
    sd_buff_wr = 1'b1;
    #1;
    checks++;
    if (sd_rd !== 1'b0 || DISK_RAM_WE !== 1'b0 || loading !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_xfer: sd_rd %b we %b loading %b, required 0 0 0", sd_rd, DISK_RAM_WE, loading);
    end
    we_seen = 0;
    repeat (3) begin
      tick();
      if (sd_rd !== 1'b0 || DISK_RAM_WE !== 1'b0) we_seen++;
    end
    RESET_N = 1'b1;
    repeat (5) begin
      tick();
      if (sd_rd !== 1'b0 || DISK_RAM_WE !== 1'b0) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      errors++;
      $display("FAIL after_reset_activity: %0d cycles with rd/we high, required 0", we_seen);
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    t = 0;
    while (sd_rd !== 1'b1 && t < WAIT_MAX) begin
      tick();
      t++;
    end
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'd65 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload_after_reset: sd_rd %b lba %0d pending writes %0d, required 1 65 0",
               sd_rd, sd_lba, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stray_strobe();
    test_boot();
    test_seek();
    test_stepping();
    test_midload_change();
    test_mount_and_seek();
    test_eject();
    test_out_of_range();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
